// File: rtl/centroid_calc.sv
// rtl/centroid_calc.sv - blob centroid sequencer with one shared restoring divider
//
// Runs one accumulator pass per accepted frame_start, captures the accumulator
// totals, divides p_x and p_y by p_size (quotient floor, saturated to X_MAX /
// Y_MAX) and holds the result on a valid/ready output.
// Fixed latency: out_valid rises 49 edges after the edge that samples acc_done.
//
// Optional feature macro: CENTROID_SMOOTH_EN
//   defined   : cx/cy = (prev + new + 1) >> 1 when this result and the last
//               transferred result both have found=1
//   undefined : raw saturated quotient, no history registers
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   frame_start  in   request one pass (IDLE only)
//   run_acc      out  registered accumulator enable
//   acc_done     in   accumulator finished, p_* valid while high
//   p_size       in   [15:0] scaled pixel count
//   p_x          in   [24:0] scaled x sum
//   p_y          in   [23:0] scaled y sum
//   out_valid    out  result valid, held until out_ready
//   out_ready    in   consumer accepts result
//   cx           out  [9:0] centroid x
//   cy           out  [8:0] centroid y
//   found        out  blob meets MIN_SIZE
//   busy         out  state != IDLE
module centroid_calc #(
  parameter logic [15:0] MIN_SIZE = 16'd4,
  parameter logic [9:0]  X_MAX    = 10'd639,
  parameter logic [8:0]  Y_MAX    = 9'd479
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  output logic        run_acc,
  input  logic        acc_done,
  input  logic [15:0] p_size,
  input  logic [24:0] p_x,
  input  logic [23:0] p_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  cx,
  output logic [8:0]  cy,
  output logic        found,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_DIV_X,
    S_DIV_Y,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [15:0] size_q;
  logic [23:0] py_q;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after the last step this register holds the quotient.
  logic [24:0] dq;
  logic [25:0] rem;
  logic [4:0]  cnt;
  logic [9:0]  cx_sat;   // saturated x quotient, parked while y divides

  logic [26:0] rem_shift;
  logic [25:0] rem_sub;
  logic [25:0] rem_next;
  logic        q_bit;
  logic [24:0] qx_final;
  logic [23:0] qy_final;
  logic [9:0]  cx_raw;
  logic [8:0]  cy_raw;
  logic [9:0]  cx_new;
  logic [8:0]  cy_new;
  logic        size_ok;

  // One restoring step per edge.
  always_comb begin
    rem_shift = {rem, dq[24]};
    rem_sub   = rem_shift[25:0] - {10'd0, size_q};
    q_bit     = (rem_shift >= {11'd0, size_q});
    rem_next  = q_bit ? rem_sub : rem_shift[25:0];
  end

  always_comb begin
    qx_final = {dq[23:0], q_bit};
    // y dividend was loaded as {p_y, 0}; after 23 steps the low 23 bits are quotient
    qy_final = {dq[22:0], q_bit};
    cx_raw   = (qx_final > {15'd0, X_MAX}) ? X_MAX : qx_final[9:0];
    cy_raw   = (qy_final > {15'd0, Y_MAX}) ? Y_MAX : qy_final[8:0];
    // a zero size is rejected even when MIN_SIZE is 0
    size_ok  = (size_q != 16'd0) && (size_q >= MIN_SIZE);
  end

`ifdef CENTROID_SMOOTH_EN
  logic        hist_valid;
  logic [9:0]  hist_cx;
  logic [8:0]  hist_cy;
  logic [10:0] sum_x;
  logic [9:0]  sum_y;

  always_comb begin
    sum_x = {1'b0, hist_cx} + {1'b0, cx_sat} + 11'd1;
    sum_y = {1'b0, hist_cy} + {1'b0, cy_raw} + 10'd1;
    if (size_ok && hist_valid) begin
      cx_new = sum_x[10:1];
      cy_new = sum_y[9:1];
    end else begin
      cx_new = cx_sat;
      cy_new = cy_raw;
    end
  end

  // History follows the transferred result; a found=0 transfer invalidates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= 1'b0;
      hist_cx    <= 10'd0;
      hist_cy    <= 9'd0;
    end else if (state == S_OUT && out_ready) begin
      hist_valid <= found;
      hist_cx    <= cx;
      hist_cy    <= cy;
    end
  end
`else
  always_comb begin
    cx_new = cx_sat;
    cy_new = cy_raw;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_start)    state_nxt = S_ACC;
      S_ACC:   if (acc_done)       state_nxt = S_DIV_X;
      S_DIV_X: if (cnt == 5'd24)   state_nxt = S_DIV_Y;
      S_DIV_Y: if (cnt == 5'd23)   state_nxt = S_OUT;
      S_OUT:   if (out_ready)      state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_acc   <= 1'b0;
      out_valid <= 1'b0;
      found     <= 1'b0;
      cx        <= 10'd0;
      cy        <= 9'd0;
      size_q    <= 16'd0;
      py_q      <= 24'd0;
      dq        <= 25'd0;
      rem       <= 26'd0;
      cnt       <= 5'd0;
      cx_sat    <= 10'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) run_acc <= 1'b1;
        end
        S_ACC: begin
          if (acc_done) begin
            run_acc <= 1'b0;
            size_q  <= p_size;
            py_q    <= p_y;
            dq      <= p_x;
            rem     <= 26'd0;
            cnt     <= 5'd0;
          end
        end
        S_DIV_X: begin
          if (cnt == 5'd24) begin
            cx_sat <= cx_raw;
            dq     <= {py_q, 1'b0};
            rem    <= 26'd0;
            cnt    <= 5'd0;
          end else begin
            dq  <= {dq[23:0], q_bit};
            rem <= rem_next;
            cnt <= cnt + 5'd1;
          end
        end
        S_DIV_Y: begin
          dq  <= {dq[23:0], q_bit};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23) begin
            found     <= size_ok;
            cx        <= size_ok ? cx_new : 10'd0;
            cy        <= size_ok ? cy_new : 9'd0;
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          run_acc   <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
